// File: rtl/nn_pkg.sv
// Shared definitions for the neural_network layers: FSM state encoding, default
// fixed-point widths and the saturating clamp used by every layer's output stage.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        BIAS  = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int DATA_W_DEF    = 8;
    localparam int FRAC_BITS_DEF = 4;
    localparam int ACC_W_DEF     = 24;

    typedef struct packed {
        logic [63:0] value;
        logic        overflow;
    } sat_t;

    // Clamp a wide signed value into a data_w-bit signed range; flag when clamped.
    function automatic sat_t sat_clamp(input logic signed [63:0] v, input int data_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_t               r;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            r.value    = hi;
            r.overflow = 1'b1;
        end else if (v < lo) begin
            r.value    = lo;
            r.overflow = 1'b1;
        end else begin
            r.value    = v;
            r.overflow = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/nn_saturate.sv
// Combinational bias add, fixed-point rescale (arithmetic shift, floor) and
// saturation of an accumulator into a DATA_W-bit signed result.
module nn_saturate
    import nn_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    input  logic signed [DATA_W-1:0] i_bias,
    output logic signed [DATA_W-1:0] o_y,
    output logic                     o_overflow
);

    // One guard bit so the bias add cannot wrap before the clamp sees it.
    logic signed [ACC_W:0] w_bias_ext;
    logic signed [ACC_W:0] w_sum;
    logic signed [ACC_W:0] w_shift;
    sat_t                  w_sat;
    logic                  w_unused_hi;

    assign w_bias_ext  = (ACC_W+1)'(i_bias) <<< FRAC_BITS;
    assign w_sum       = (ACC_W+1)'(i_acc) + w_bias_ext;
    assign w_shift     = w_sum >>> FRAC_BITS;
    assign w_sat       = sat_clamp(64'(w_shift), DATA_W);
    assign o_y         = w_sat.value[DATA_W-1:0];
    assign o_overflow  = w_sat.overflow;
    assign w_unused_hi = ^w_sat.value[63:DATA_W];

endmodule

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate stage with bias, rescale, saturation and
// optional ReLU (define NEURON_RELU_EN), valid/ready on both input and output.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int N_INPUTS  = 16,
    parameter int ACC_W     = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_en,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] y,
    output logic                     overflow,
    output logic                     busy
);

    // Handshakes: a transfer happens on a rising edge with clk_en=1 where
    // valid and ready are both high; ready/valid come straight from the state.

    localparam int CNT_W = $clog2(N_INPUTS + 1);

    state_t                    r_state;
    state_t                    w_next;
    logic signed [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]          r_cnt;
    logic signed [DATA_W-1:0]  r_bias;
    logic signed [DATA_W-1:0]  r_y;
    logic                      r_ovf;

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic                       w_last_beat;
    logic signed [DATA_W-1:0]   w_sat_y;
    logic                       w_sat_ovf;
    logic signed [DATA_W-1:0]   w_act_y;

    assign w_prod      = x * w;
    assign w_prod_ext  = ACC_W'(w_prod);
    assign w_last_beat = (r_cnt == CNT_W'(N_INPUTS - 1));

    nn_saturate #(
        .ACC_W    (ACC_W),
        .DATA_W   (DATA_W),
        .FRAC_BITS(FRAC_BITS)
    ) u_sat (
        .i_acc     (r_acc),
        .i_bias    (r_bias),
        .o_y       (w_sat_y),
        .o_overflow(w_sat_ovf)
    );

`ifdef NEURON_RELU_EN
    assign w_act_y = w_sat_y[DATA_W-1] ? '0 : w_sat_y;
`else
    assign w_act_y = w_sat_y;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (clk_en) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = ACCUM;
            ACCUM:   if (in_valid && w_last_beat) w_next = BIAS;
            BIAS:    w_next = OUT;
            OUT:     if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ACCUM);
        out_valid = (r_state == OUT);
        busy      = (r_state != IDLE);
        y         = r_y;
        overflow  = r_ovf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_bias <= '0;
            r_y    <= '0;
            r_ovf  <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bias <= bias;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        r_acc <= r_acc + w_prod_ext;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BIAS: begin
                    r_y   <= w_act_y;
                    r_ovf <= w_sat_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed self-checking bench for neuron_mac (DATA_W=8, FRAC_BITS=4, N_INPUTS=4, ACC_W=24);
// expectations follow NEURON_RELU_EN when it is defined.
module tb_neuron_mac;

`ifdef NEURON_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b0;
    logic       start = 1'b0;
    logic [7:0] bias = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] x = '0;
    logic [7:0] w = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] y;
    logic       overflow;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    neuron_mac #(
        .DATA_W   (8),
        .FRAC_BITS(4),
        .N_INPUTS (4),
        .ACC_W    (24)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .start    (start),
        .bias     (bias),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .w        (w),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_eval(input logic [7:0] b);
        bias  = b;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic send_beat(input logic [7:0] bx, input logic [7:0] bw);
        bit hs;
        hs       = 1'b0;
        x        = bx;
        w        = bw;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !hs; i++) begin
            hs = (in_ready === 1'b1) && clk_en;
            step();
        end
        chk("beat_accepted", 32'(hs), 32'd1);
    endtask

    task automatic release_out(input string tag, input logic [7:0] exp_y);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_y_held"}, 32'(y), 32'(exp_y));
    endtask

    task automatic run_eval(input string tag, input logic [7:0] b,
                            input logic [7:0] xs[4], input logic [7:0] ws[4],
                            input logic [7:0] exp_y, input logic exp_ovf);
        start_eval(b);
        for (int i = 0; i < 4; i++) send_beat(xs[i], ws[i]);
        in_valid = 1'b0;
        chk({tag, "_bias_cycle_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_bias_cycle_ready"}, 32'(in_ready), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_y"}, 32'(y), 32'(exp_y));
        chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        release_out(tag, exp_y);
    endtask

    initial begin
        logic [7:0] xs[4];
        logic [7:0] ws[4];

        // Reset while clk_en is low must still clear everything
        rst_n  = 1'b0;
        clk_en = 1'b0;
        step();
        step();
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n  = 1'b1;
        clk_en = 1'b1;
        step();

        // Basic: 4 x (1.0 * 0.5) + 1.0 = 3.0
        xs = '{8'h10, 8'h10, 8'h10, 8'h10};
        ws = '{8'h08, 8'h08, 8'h08, 8'h08};
        run_eval("basic", 8'h10, xs, ws, 8'h30, 1'b0);

        // Negative: 4 x (1.0 * -1.0) = -4.0
        ws = '{8'hF0, 8'hF0, 8'hF0, 8'hF0};
        run_eval("negative", 8'h00, xs, ws, RELU ? 8'h00 : 8'hC0, 1'b0);

        // Positive and negative saturation
        xs = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
        ws = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
        run_eval("sat_pos", 8'h7F, xs, ws, 8'h7F, 1'b1);
        xs = '{8'h80, 8'h80, 8'h80, 8'h80};
        run_eval("sat_neg", 8'h80, xs, ws, RELU ? 8'h00 : 8'h80, 1'b1);

        // Floor rounding: -4/256 rescales to -1 LSB, not 0
        xs = '{8'h01, 8'h01, 8'h01, 8'h01};
        ws = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_eval("floor", 8'h00, xs, ws, RELU ? 8'h00 : 8'hFF, 1'b0);

        // Mixed terms: 1.0 + 2.0 - 2.0 - 0.25 + 0.0625 = 0.8125
        xs = '{8'h10, 8'h20, 8'hF0, 8'h08};
        ws = '{8'h10, 8'h10, 8'h20, 8'hF8};
        run_eval("mixed", 8'h01, xs, ws, 8'h0D, 1'b0);

        // Gaps on input, backpressure on output: 4 x 1.5 - 2.0 = 4.0
        start_eval(8'hE0);
        for (int i = 0; i < 4; i++) begin
            send_beat(8'h18, 8'h10);
            in_valid = 1'b0;
            step();
        end
        chk("gap_valid", 32'(out_valid), 32'd1);
        chk("gap_y", 32'(y), 32'h40);
        chk("gap_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 5; i++) begin
            start = (i == 1 || i == 2);
            step();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_y", 32'(y), 32'h40);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        start = 1'b0;
        release_out("gap", 8'h40);
        step();
        chk("gap_start_ignored", 32'(busy), 32'd0);

        // Clock enable stall after beat 2, in_valid held high
        start_eval(8'h10);
        send_beat(8'h10, 8'h08);
        send_beat(8'h10, 8'h08);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("cen_in_ready", 32'(in_ready), 32'd1);
        chk("cen_busy", 32'(busy), 32'd1);
        chk("cen_out_valid", 32'(out_valid), 32'd0);
        clk_en = 1'b1;
        send_beat(8'h10, 8'h08);
        send_beat(8'h10, 8'h08);
        in_valid = 1'b0;
        step();
        chk("cen_valid", 32'(out_valid), 32'd1);
        chk("cen_y", 32'(y), 32'h30);
        release_out("cen", 8'h30);

        // Reset mid-evaluation (clk_en low) drops partial work
        start_eval(8'h7F);
        for (int i = 0; i < 3; i++) send_beat(8'h7F, 8'h7F);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        clk_en   = 1'b0;
        step();
        rst_n  = 1'b1;
        clk_en = 1'b1;
        chk("mid_rst_y", 32'(y), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        xs = '{8'h10, 8'h10, 8'h10, 8'h10};
        ws = '{8'h08, 8'h08, 8'h08, 8'h08};
        run_eval("after_rst", 8'h10, xs, ws, 8'h30, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
